// File: rtl/mul_seq.sv
// Sequential shift-add multiplier for the EX stage; one bit per RUN cycle.
// Optional MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier is zero.
module mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [10:0]      funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [10:0] FUNCT_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic last;
  logic [WIDTH-1:0] mplier_sh;

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, shift-add step and handshake outputs
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = start && (funct == FUNCT_MUL) && !flush;
    mplier_sh = mplier_q >> 1;
`ifdef MUL_EARLY_TERM_EN
    last      = (cnt_q == LAST) || (mplier_sh == '0);
`else
    last      = (cnt_q == LAST);
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_sh;
          cnt_d    = cnt_q + 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        done    = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = acc_q;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  EX-stage request valid.
REQ-005 SHALL have port funct  input  11  EX-stage instruction funct field.
REQ-006 SHALL have port a  input  WIDTH  multiplicand (Rn value).
REQ-007 SHALL have port b  input  WIDTH  multiplier (Rm value).
REQ-008 SHALL have port flush  input  1  abort the operation in progress.
REQ-009 SHALL have port stall  output  1  freeze IF/ID/EX pipeline registers.
REQ-010 SHALL have port busy  output  1  high while in state RUN.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port result  output  WIDTH  low WIDTH bits of a*b.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE, with registers acc, mcand, mplier (WIDTH each) and an iteration counter cnt of clog2(WIDTH) bits.
REQ-014 SHALL accept a request only in IDLE when start=1, funct=11'b10011011000 (MUL) and flush=0: load acc=0, mcand=a, mplier=b, cnt=0, then go to RUN.
REQ-015 SHALL ignore start with any other funct, and any start in RUN or DONE.
REQ-016 SHALL drive stall combinationally high in IDLE during a qualifying request, and in RUN; stall SHALL be low in DONE and otherwise.
REQ-017 SHALL perform one step per RUN cycle: if mplier[0]=1 then acc += mcand (mod 2^WIDTH); mcand shifts left 1; mplier shifts right 1 (logical); cnt increments.
REQ-018 SHALL leave RUN for DONE after the step in which cnt = WIDTH-1, giving exactly WIDTH RUN cycles (64 at default).
REQ-019 SHALL discard carries beyond bit WIDTH-1 and treat operands as unsigned; the low WIDTH bits are therefore also correct for two's-complement operands.
REQ-020 SHALL assert done for exactly the DONE cycle and return to IDLE on the next cycle.
REQ-021 SHALL drive result from acc; acc SHALL hold its value from DONE until the next accepted request.
REQ-022 SHALL, on flush=1 in RUN or DONE, return to IDLE on the next edge with no done pulse; acc SHALL be left unchanged.
REQ-023 SHALL give flush priority over start in IDLE, so no request is accepted.
REQ-024 SHALL give latency from the accept edge to done high of WIDTH+1 cycles without early termination.

Reset
REQ-025 SHALL, while reset=1, asynchronously force state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, so that stall=0, busy=0, done=0, result=0.
REQ-026 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse after reset is released.

Configuration
REQ-027 SHALL honour macro MUL_EARLY_TERM_EN: when defined, RUN SHALL also exit to DONE after any step whose post-shift mplier equals 0 (b=0 gives 1 RUN cycle; b=1 gives 1 RUN cycle; b=8 gives 4 RUN cycles).
REQ-028 SHALL, when MUL_EARLY_TERM_EN is undefined, always use WIDTH RUN cycles regardless of operand values; result values SHALL be identical in both builds.

Verification
REQ-029 SHALL cover: MUL request a=3, b=5 -> stall high 65 cycles from the accept cycle, done pulses once at accept+65, result=15, busy low after done.
REQ-030 SHALL cover: a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> result=64'hFFFF_FFFF_FFFF_FFFE (overflow discarded).
REQ-031 SHALL cover: start with funct=11'b10001011000 (ADD) -> stall stays 0, state stays IDLE, no done.
REQ-032 SHALL cover: flush at RUN cycle 10 -> IDLE on the next cycle, no done, stall low; a following MUL a=7, b=6 -> result=42.
REQ-033 SHALL cover: reset pulsed mid-RUN -> stall/busy/done/result=0 immediately while reset is high; no done after release.
REQ-034 SHALL cover: with MUL_EARLY_TERM_EN, a=9, b=8 -> done at accept+5, result=72; with b=0 -> done at accept+2, result=0.
